mdu_e: RTL and testbench

MDU_E -- requirements
Module: mdu_E

---
 rtl/mdu_e.sv | 155 +++++++++++++++
 tb/tb_mdu_e.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mdu_e.sv
// -----------------------------------------------------------------------------
// mdu_e : E-stage multiply/divide unit with architectural HI/LO registers.
//
// Accepts mult/multu/div/divu (multi-cycle, Busy asserted while running) and
// mthi/mtlo (single-edge writes, no Busy). Operands are captured at the
// accepting edge; the result is written to HI/LO at the completion edge.
//
// Ports:
//   clk    in   1  single clock, rising edge
//   reset  in   1  synchronous active-high reset
//   Start  in   1  an E-stage md instruction is valid this cycle
//   MDop   in   3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   SrcA   in  32  rs operand
//   SrcB   in  32  rt operand
//   Flush  in   1  cancel the E-stage instruction this cycle
//   Busy   out  1  multi-cycle operation in progress (registered)
//   HI     out 32  architectural HI register
//   LO     out 32  architectural LO register
// -----------------------------------------------------------------------------
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDop,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Counter only has to hold N-1 for the longer of the two operations.
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_op;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic          w_accept;
  logic          w_is_mul;
  logic [63:0]   w_mul_a;
  logic [63:0]   w_mul_b;
  logic [63:0]   w_prod;
  logic          w_sdiv;
  logic          w_neg_a;
  logic          w_neg_b;
  logic [31:0]   w_dvd;
  logic [31:0]   w_dvs;
  logic          w_div_zero;
  logic [31:0]   w_dvs_safe;
  logic [31:0]   w_qmag;
  logic [31:0]   w_rmag;
  logic [31:0]   w_quot;
  logic [31:0]   w_rem;

  assign w_accept = Start && !Flush && (r_state == S_IDLE) &&
                    (MDop != 3'd0) && (MDop != 3'd7);

  assign w_is_mul = (r_op == OP_MULT) || (r_op == OP_MULTU);

  // Sign-extend for mult, zero-extend for multu; the low 64 bits of the
  // 64x64 product are then the correct signed/unsigned 64-bit result.
  assign w_mul_a = {{32{(r_op == OP_MULT) & r_a[31]}}, r_a};
  assign w_mul_b = {{32{(r_op == OP_MULT) & r_b[31]}}, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed division is done on magnitudes so 0x80000000 / -1 falls out
  // naturally as 0x80000000 with no overflow special case.
  assign w_sdiv     = (r_op == OP_DIV);
  assign w_neg_a    = w_sdiv & r_a[31];
  assign w_neg_b    = w_sdiv & r_b[31];
  assign w_dvd      = w_neg_a ? -r_a : r_a;
  assign w_dvs      = w_neg_b ? -r_b : r_b;
  assign w_div_zero = (r_b == 32'd0);
  // Divisor forced non-zero only to keep the divider defined; the result is
  // discarded when the real divisor is zero.
  assign w_dvs_safe = w_div_zero ? 32'd1 : w_dvs;
  assign w_qmag     = w_dvd / w_dvs_safe;
  assign w_rmag     = w_dvd % w_dvs_safe;
  assign w_quot     = (w_neg_a ^ w_neg_b) ? -w_qmag : w_qmag;
  assign w_rem      = w_neg_a ? -w_rmag : w_rmag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (MDop)
              OP_MTHI: r_hi <= SrcA;
              OP_MTLO: r_lo <= SrcA;
              default: begin
                r_state <= S_RUN;
                r_op    <= MDop;
                r_a     <= SrcA;
                r_b     <= SrcB;
                if ((MDop == OP_MULT) || (MDop == OP_MULTU))
                  r_cnt <= CW'(MULT_CYCLES - 1);
                else
                  r_cnt <= CW'(DIV_CYCLES - 1);
              end
            endcase
          end
        end
        S_RUN: begin
          // Flush is deliberately not looked at here: the op is committed.
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            if (w_is_mul) begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end else if (!w_div_zero) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy = (r_state == S_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_e.sv
module tb_mdu_e;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDop;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Flush;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDop  (MDop),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .Flush (Flush),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  // Issue one op from posedge+1, then count Busy cycles while scrambling the
  // operand inputs; returns at posedge+1 of the first Busy=0 cycle.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    Start = 1'b1; MDop = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    Start = 1'b0; MDop = 3'd0;
    cyc = 0;
    while (Busy && cyc < 200) begin
      cyc++;
      SrcA = $urandom; SrcB = $urandom;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] hold_hi, hold_lo;

    vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MC};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[3]  = '{3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, DC};
    vecs[4]  = '{3'd5, 32'h12345678, 32'd9,        32'h12345678, 32'h00000003, 0};
    vecs[5]  = '{3'd4, 32'd100,      32'd0,        32'h12345678, 32'h00000003, DC};
    vecs[6]  = '{3'd6, 32'hCAFEBABE, 32'd1,        32'h12345678, 32'hCAFEBABE, 0};
    vecs[7]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    vecs[8]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
    vecs[9]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
    vecs[10] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
    vecs[11] = '{3'd3, 32'd5,        32'd0,        32'hFFFFFFFE, 32'h00000001, DC};
    vecs[12] = '{3'd7, 32'h11111111, 32'd2,        32'hFFFFFFFE, 32'h00000001, 0};
    vecs[13] = '{3'd0, 32'h22222222, 32'd2,        32'hFFFFFFFE, 32'h00000001, 0};

    reset = 1'b1; Start = 1'b0; MDop = 3'd0; SrcA = '0; SrcB = '0; Flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    $display("reset: busy=%0d hi=%08h lo=%08h", Busy, HI, LO);

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      $display("vec %0d: op=%0d a=%08h b=%08h busy_cycles=%0d hi=%08h lo=%08h",
               i, vecs[i].op, vecs[i].a, vecs[i].b, cyc, HI, LO);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
      chk($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
    end

    // Start with Flush at the accepting edge: nothing happens.
    hold_hi = HI; hold_lo = LO;
    Start = 1'b1; Flush = 1'b1; MDop = 3'd1; SrcA = 32'd6; SrcB = 32'd7;
    @(posedge clk); #1;
    chk("flush_accept_busy", {31'd0, Busy}, 32'd0);
    Start = 1'b0; Flush = 1'b0; MDop = 3'd0;
    repeat (MC + 1) @(posedge clk);
    #1;
    chk("flush_accept_busy_later", {31'd0, Busy}, 32'd0);
    chk("flush_accept_hi", HI, hold_hi);
    chk("flush_accept_lo", LO, hold_lo);
    $display("flush at accept: busy=%0d hi=%08h lo=%08h", Busy, HI, LO);

    // Flush during RUN cycle 2 does not abort.
    Start = 1'b1; MDop = 3'd1; SrcA = 32'd6; SrcB = 32'd7;
    @(posedge clk); #1;
    Start = 1'b0; MDop = 3'd0;
    cyc = 0;
    while (Busy && cyc < 200) begin
      cyc++;
      Flush = (cyc == 2);
      @(posedge clk); #1;
    end
    Flush = 1'b0;
    chk("flush_run_cycles", 32'(cyc), 32'(MC));
    chk("flush_run_hi", HI, 32'd0);
    chk("flush_run_lo", LO, 32'd42);
    $display("flush during run: busy_cycles=%0d hi=%08h lo=%08h", cyc, HI, LO);

    // Reset on RUN cycle 3 discards the operation with no late write.
    do_op(3'd5, 32'hAAAA5555, 32'd0, cyc);
    chk("pre_reset_hi", HI, 32'hAAAA5555);
    Start = 1'b1; MDop = 3'd1; SrcA = 32'hFFFFFFFF; SrcB = 32'hFFFFFFFF;
    @(posedge clk); #1;
    Start = 1'b0; MDop = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("run_reset_busy", {31'd0, Busy}, 32'd0);
    chk("run_reset_hi", HI, 32'd0);
    chk("run_reset_lo", LO, 32'd0);
    repeat (MC + 2) @(posedge clk);
    #1;
    chk("run_reset_late_busy", {31'd0, Busy}, 32'd0);
    chk("run_reset_late_hi", HI, 32'd0);
    chk("run_reset_late_lo", LO, 32'd0);
    $display("reset during run: busy=%0d hi=%08h lo=%08h", Busy, HI, LO);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
